// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU operations, FSM state codes and datapath mux selects.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Codes 12..15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation decode; unknown functs fall back to ADD
// and raise o_funct_illegal so the caller can suppress the writeback.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_funct_illegal
);

    // Combinational funct lookup
    always_comb begin
        o_alu_op        = ALU_ADD;
        o_funct_illegal = 1'b0;
        case (i_funct)
            FN_ADD:  o_alu_op = ALU_ADD;
            FN_SUB:  o_alu_op = ALU_SUB;
            FN_AND:  o_alu_op = ALU_AND;
            FN_OR:   o_alu_op = ALU_OR;
            FN_SLT:  o_alu_op = ALU_SLT;
            default: begin
                o_alu_op        = ALU_ADD;
                o_funct_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute, memory and
// writeback over a shared ALU/memory datapath, one instruction at a time.
module mips_multicycle_ctrl
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_funct_illegal;
    logic [2:0] w_dec_alu_op;
    logic       w_dec_illegal;

    mips_alu_decoder u_alu_dec (
        .i_funct         (funct),
        .o_alu_op        (w_dec_alu_op),
        .o_funct_illegal (w_dec_illegal)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember an illegal funct seen in EXEC so ALUWB can drop the write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct_illegal <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_funct_illegal <= w_dec_illegal;
        end else begin
            r_funct_illegal <= r_funct_illegal;
        end
    end

    // Next-state and Moore outputs; reset overrides with FETCH values minus enables
    always_comb begin
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REGB;
        alu_op       = ALU_ADD;
        pc_src       = PCSRC_ALU;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        w_next_state = S_FETCH;

        if (reset) begin
            alu_src_b    = SRCB_FOUR;
            alu_op       = ALU_ADD;
            w_next_state = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    ir_write     = 1'b1;
                    pc_en        = 1'b1;
                    alu_src_b    = SRCB_FOUR;
                    w_next_state = S_DECODE;
                end
                S_DECODE: begin
                    // Branch target computed speculatively into ALUOut
                    alu_src_b = SRCB_IMM_SH2;
                    if (is_mem_op(opcode)) begin
                        w_next_state = S_MEMADR;
                    end else begin
                        case (opcode)
                            OP_RTYPE: w_next_state = S_EXEC;
                            OP_BEQ:   w_next_state = S_BRANCH;
                            OP_ADDI:  w_next_state = S_ADDIEX;
                            OP_J:     w_next_state = S_JUMP;
                            default: begin
                                w_next_state = S_FETCH;
                                illegal_op   = 1'b1;
                                instr_done   = 1'b1;
                            end
                        endcase
                    end
                end
                S_MEMADR: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    iord         = 1'b1;
                    w_next_state = S_MEMWB;
                end
                S_MEMWB: begin
                    mem_to_reg   = 1'b1;
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_MEMWR: begin
                    iord         = 1'b1;
                    mem_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a    = 1'b1;
                    alu_op       = w_dec_alu_op;
                    illegal_op   = w_dec_illegal;
                    w_next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_dst      = 1'b1;
                    reg_write    = ~r_funct_illegal;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a    = 1'b1;
                    alu_op       = ALU_SUB;
                    pc_src       = PCSRC_ALUOUT;
                    pc_en        = zero_flag;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_ADDIEX: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    w_next_state = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_src       = PCSRC_JUMP;
                    pc_en        = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle
// by cycle and compares the whole control word against hand-built vectors.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero_flag;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero_flag  (zero_flag),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word layout:
    // pc_en iord mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a
    // alu_src_b[1:0] alu_op[2:0] pc_src[1:0] instr_done illegal_op
    function automatic logic [16:0] mk(input logic pe, input logic io, input logic mw,
                                       input logic iw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] aop, input logic [1:0] ps,
                                       input logic dn, input logic il);
        return {pe, io, mw, iw, rd, m2r, rw, sa, sb, aop, ps, dn, il};
    endfunction

    function automatic logic [16:0] observed();
        return {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};
    endfunction

    logic [16:0] V_RESET, V_FETCH, V_DECODE, V_DECODE_ILL, V_MEMADR, V_MEMRD, V_MEMWB;
    logic [16:0] V_MEMWR, V_ADDIEX, V_ADDIWB, V_JUMP;

    task automatic check_eq(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Check the current cycle's outputs, then advance to the next falling edge
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check_eq(tag, observed(), exp);
        @(negedge clk);
    endtask

    logic [5:0] rt_funct [5];
    logic [2:0] rt_aop   [5];

    initial begin
        V_RESET      = mk(0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        V_FETCH      = mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0);
        V_DECODE     = mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
        V_DECODE_ILL = mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,1,1);
        V_MEMADR     = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        V_MEMRD      = mk(0,1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
        V_MEMWB      = mk(0,0,0,0,0,1,1,0,2'b00,3'b010,2'b00,1,0);
        V_MEMWR      = mk(0,1,1,0,0,0,0,0,2'b00,3'b010,2'b00,1,0);
        V_ADDIEX     = mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
        V_ADDIWB     = mk(0,0,0,0,0,0,1,0,2'b00,3'b010,2'b00,1,0);
        V_JUMP       = mk(1,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0);

        rt_funct[0] = 6'b100000; rt_aop[0] = 3'b010;
        rt_funct[1] = 6'b100010; rt_aop[1] = 3'b110;
        rt_funct[2] = 6'b100100; rt_aop[2] = 3'b000;
        rt_funct[3] = 6'b100101; rt_aop[3] = 3'b001;
        rt_funct[4] = 6'b101010; rt_aop[4] = 3'b111;

        reset = 1'b1; opcode = 6'b100011; funct = 6'b000000; zero_flag = 1'b0;
        @(negedge clk);
        cyc("reset_c0", V_RESET);
        cyc("reset_c1", V_RESET);

        // lw: 5 cycles; opcode change in MEMRD must be ignored
        reset = 1'b0;
        cyc("lw_fetch", V_FETCH);
        cyc("lw_decode", V_DECODE);
        cyc("lw_memadr", V_MEMADR);
        opcode = 6'b000000;
        cyc("lw_memrd", V_MEMRD);
        cyc("lw_memwb", V_MEMWB);

        // R-type sweep; funct garbage in ALUWB must not affect the write
        for (int i = 0; i < 5; i++) begin
            opcode = 6'b000000; funct = rt_funct[i];
            cyc($sformatf("rt%0d_fetch", i), V_FETCH);
            cyc($sformatf("rt%0d_decode", i), V_DECODE);
            cyc($sformatf("rt%0d_exec", i), mk(0,0,0,0,0,0,0,1,2'b00,rt_aop[i],2'b00,0,0));
            funct = 6'b000111;
            cyc($sformatf("rt%0d_aluwb", i), mk(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,1,0));
        end

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100; zero_flag = z[0];
            cyc($sformatf("beq%0d_fetch", z), V_FETCH);
            cyc($sformatf("beq%0d_decode", z), V_DECODE);
            cyc($sformatf("beq%0d_branch", z), mk(z[0],0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0));
        end
        zero_flag = 1'b0;

        // addi
        opcode = 6'b001000;
        cyc("addi_fetch", V_FETCH);
        cyc("addi_decode", V_DECODE);
        cyc("addi_ex", V_ADDIEX);
        cyc("addi_wb", V_ADDIWB);

        // sw then j back-to-back: 7 cycles
        opcode = 6'b101011;
        cyc("sw_fetch", V_FETCH);
        cyc("sw_decode", V_DECODE);
        cyc("sw_memadr", V_MEMADR);
        cyc("sw_memwr", V_MEMWR);
        opcode = 6'b000010;
        cyc("j_fetch", V_FETCH);
        cyc("j_decode", V_DECODE);
        cyc("j_jump", V_JUMP);

        // Illegal opcode: 2 cycles
        opcode = 6'b111111;
        cyc("illop_fetch", V_FETCH);
        cyc("illop_decode", V_DECODE_ILL);

        // Illegal funct: write suppressed in ALUWB
        opcode = 6'b000000; funct = 6'b000111;
        cyc("illfn_fetch", V_FETCH);
        cyc("illfn_decode", V_DECODE);
        cyc("illfn_exec", mk(0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1));
        funct = 6'b100000;
        cyc("illfn_aluwb", mk(0,0,0,0,1,0,0,0,2'b00,3'b010,2'b00,1,0));

        // Following legal R-type must write again
        funct = 6'b100010;
        cyc("rtok_fetch", V_FETCH);
        cyc("rtok_decode", V_DECODE);
        cyc("rtok_exec", mk(0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0));
        cyc("rtok_aluwb", mk(0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,1,0));

        // Reset during MEMWR of sw aborts the store
        opcode = 6'b101011;
        cyc("swrst_fetch", V_FETCH);
        cyc("swrst_decode", V_DECODE);
        cyc("swrst_memadr", V_MEMADR);
        reset = 1'b1;
        cyc("swrst_memwr", V_RESET);
        reset = 1'b0;
        cyc("swrst_refetch", V_FETCH);
        cyc("swrst_redecode", V_DECODE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
